// File: rtl/rv_lsu_stage_if.sv
// ---------------------------------------------------------------------------
// rv_lsu_stage_if
// Request/acknowledge data-bus bundle between the load/store stage and memory.
//
// Parameters:
//   XLEN  - data/address width (32 or 64); byte-enable width is XLEN/8
//
// Signals:
//   req    stage -> mem   access request, held until ack is sampled
//   we     stage -> mem   1 = store, 0 = load
//   addr   stage -> mem   bus-word aligned address
//   sel    stage -> mem   byte enables
//   wdata  stage -> mem   lane-replicated store data
//   ack    mem -> stage   access complete; rdata valid on loads
//   rdata  mem -> stage   load data (full bus word)
//
// Modports: master (the stage), slave (the memory side).
// ---------------------------------------------------------------------------
interface rv_lsu_stage_if #(
    parameter int XLEN = 32
) ();
    localparam int SEL_W = XLEN / 8;

    logic             req;
    logic             we;
    logic [XLEN-1:0]  addr;
    logic [SEL_W-1:0] sel;
    logic [XLEN-1:0]  wdata;
    logic             ack;
    logic [XLEN-1:0]  rdata;

    modport master (output req, we, addr, sel, wdata, input ack, rdata);
    modport slave  (input req, we, addr, sel, wdata, output ack, rdata);
endinterface

// File: rtl/rv_lsu_stage.sv
// ---------------------------------------------------------------------------
// rv_lsu_stage
// Load/store pipeline stage between execute and writeback, XLEN 32 or 64.
// Non-memory instructions pass through with one cycle of latency. Loads and
// stores raise a bus request, stall upstream until the bus acknowledges, and
// return sign- or zero-extended load data to writeback.
//
// Optional feature macro: RV_LSU_MISALIGN_TRAP_EN
//   defined   - misaligned accesses skip the bus and report o_misalign with
//               the faulting address on o_result
//   undefined - o_misalign is 0; low address bits below the access size are
//               ignored so every access is forced aligned
//
// Ports:
//   i_clk, i_reset_n      clock, asynchronous active-low reset
//   i_valid / o_stall     upstream instruction valid / stage busy
//   i_alu_result          effective address or ALU result
//   i_rs2_val             store data
//   i_mem_read/i_mem_write  load / store
//   i_funct3              [1:0] size B/H/W/D, [2] unsigned load
//   i_rd, i_reg_write     destination register and its write enable
//   bus                   request/ack data bus (master modport)
//   o_valid, o_rd, o_reg_write, o_result   writeback result (1-cycle pulse)
//   o_misalign            misaligned access flag
// ---------------------------------------------------------------------------
module rv_lsu_stage #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_valid,
    output logic            o_stall,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic [XLEN-1:0] i_rs2_val,
    input  logic            i_mem_read,
    input  logic            i_mem_write,
    input  logic [2:0]      i_funct3,
    input  logic [4:0]      i_rd,
    input  logic            i_reg_write,
    rv_lsu_stage_if.master  bus,
    output logic            o_valid,
    output logic [4:0]      o_rd,
    output logic            o_reg_write,
    output logic [XLEN-1:0] o_result,
    output logic            o_misalign
);
    localparam int SEL_W = XLEN / 8;
    localparam int OFF_W = $clog2(SEL_W);

    typedef enum logic {IDLE, REQ} state_t;
    state_t state;

    // Doubleword accesses collapse to word accesses on a 32-bit datapath.
    function automatic logic [1:0] eff_size(input logic [1:0] f);
        return (XLEN == 32 && f == 2'd3) ? 2'd2 : f;
    endfunction

    function automatic logic [SEL_W-1:0] lane_sel(input logic [1:0] sz,
                                                  input logic [OFF_W-1:0] off);
        logic [SEL_W-1:0] m;
        case (sz)
            2'd0:    m = SEL_W'(1);
            2'd1:    m = SEL_W'(3);
            2'd2:    m = SEL_W'(15);
            default: m = '1;
        endcase
        return m << off;
    endfunction

    // Store data is replicated into every lane so the byte enables alone
    // pick the destination bytes.
    function automatic logic [XLEN-1:0] lane_wdata(input logic [1:0] sz,
                                                   input logic [XLEN-1:0] d);
        case (sz)
            2'd0:    return {SEL_W{d[7:0]}};
            2'd1:    return {(SEL_W/2){d[15:0]}};
            2'd2:    return {(XLEN/32){d[31:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rdata,
                                                    input logic [OFF_W-1:0] off,
                                                    input logic [2:0] f3);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] r;
        sh = rdata >> {off, 3'b000};
        case (eff_size(f3[1:0]))
            2'd0: r = f3[2] ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0]));
            2'd1: r = f3[2] ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]));
            2'd2: r = f3[2] ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]));
            default: r = sh;
        endcase
        return r;
    endfunction

    logic [1:0]       sz_c;
    logic [OFF_W-1:0] low_c;
    logic [OFF_W-1:0] lowmask_c;
    logic [OFF_W-1:0] off_c;
    logic             take_c;
    logic             is_mem_c;
    logic             trap_c;

    always_comb begin
        sz_c      = eff_size(i_funct3[1:0]);
        low_c     = i_alu_result[OFF_W-1:0];
        lowmask_c = OFF_W'((4'd1 << sz_c) - 4'd1);
        off_c     = low_c & ~lowmask_c;
    end

    assign take_c   = i_valid && !o_stall;
    assign is_mem_c = i_mem_read || i_mem_write;
    assign o_stall  = (state != IDLE);

`ifdef RV_LSU_MISALIGN_TRAP_EN
    assign trap_c = |(low_c & lowmask_c);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) o_misalign <= 1'b0;
        else            o_misalign <= take_c && is_mem_c && trap_c;
    end
`else
    assign trap_c     = 1'b0;
    assign o_misalign = 1'b0;
`endif

    // ---- p0: access context held for the duration of the bus access ----
    logic [2:0]       funct3_p0;
    logic [OFF_W-1:0] off_p0;
    logic [4:0]       rd_p0;
    logic             reg_write_p0;

    always_ff @(posedge i_clk) begin
        if (take_c && is_mem_c && !trap_c) begin
            funct3_p0 <= i_funct3;
            off_p0    <= off_c;
            rd_p0     <= i_rd;
        end
    end

    // ---- p1: FSM, bus drive and writeback result ----
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= IDLE;
            reg_write_p0 <= 1'b0;
            bus.req      <= 1'b0;
            bus.we       <= 1'b0;
            bus.addr     <= '0;
            bus.sel      <= '0;
            bus.wdata    <= '0;
            o_valid      <= 1'b0;
            o_rd         <= '0;
            o_reg_write  <= 1'b0;
            o_result     <= '0;
        end else begin
            o_valid     <= 1'b0;
            o_reg_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (take_c) begin
                        if (!is_mem_c) begin
                            o_valid     <= 1'b1;
                            o_result    <= i_alu_result;
                            o_rd        <= i_rd;
                            o_reg_write <= i_reg_write;
                        end else if (trap_c) begin
                            o_valid  <= 1'b1;
                            o_result <= i_alu_result;
                            o_rd     <= i_rd;
                        end else begin
                            state        <= REQ;
                            reg_write_p0 <= i_reg_write && !i_mem_write;
                            bus.req      <= 1'b1;
                            bus.we       <= i_mem_write;
                            bus.addr     <= {i_alu_result[XLEN-1:OFF_W], OFF_W'(0)};
                            bus.sel      <= lane_sel(sz_c, off_c);
                            bus.wdata    <= lane_wdata(sz_c, i_rs2_val);
                        end
                    end
                end
                REQ: begin
                    if (bus.ack) begin
                        state       <= IDLE;
                        bus.req     <= 1'b0;
                        o_valid     <= 1'b1;
                        o_rd        <= rd_p0;
                        o_reg_write <= reg_write_p0;
                        o_result    <= bus.we ? '0 : load_extend(bus.rdata, off_p0, funct3_p0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_lsu_stage.sv
module tb_rv_lsu_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // XLEN=32 instance signals
    logic        valid, mr, mw, rw;
    logic [31:0] alu, rs2;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        stall, ov, orw, omis;
    logic [4:0]  ord;
    logic [31:0] ores;

    // XLEN=64 instance signals
    logic        w_valid, w_mr, w_mw, w_rw;
    logic [63:0] w_alu, w_rs2;
    logic [2:0]  w_f3;
    logic [4:0]  w_rd;
    logic        w_stall, w_ov, w_orw, w_omis;
    logic [4:0]  w_ord;
    logic [63:0] w_ores;

    rv_lsu_stage_if #(.XLEN(32)) b32 ();
    rv_lsu_stage_if #(.XLEN(64)) b64 ();

    rv_lsu_stage #(.XLEN(32)) dut32 (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .o_stall(stall),
        .i_alu_result(alu), .i_rs2_val(rs2), .i_mem_read(mr), .i_mem_write(mw),
        .i_funct3(f3), .i_rd(rd), .i_reg_write(rw), .bus(b32),
        .o_valid(ov), .o_rd(ord), .o_reg_write(orw), .o_result(ores), .o_misalign(omis)
    );

    rv_lsu_stage #(.XLEN(64)) dut64 (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(w_valid), .o_stall(w_stall),
        .i_alu_result(w_alu), .i_rs2_val(w_rs2), .i_mem_read(w_mr), .i_mem_write(w_mw),
        .i_funct3(w_f3), .i_rd(w_rd), .i_reg_write(w_rw), .bus(b64),
        .o_valid(w_ov), .o_rd(w_ord), .o_reg_write(w_orw), .o_result(w_ores), .o_misalign(w_omis)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic r, input logic w, input logic [2:0] f,
                         input logic [4:0] dst, input logic we_rd);
        valid = v; alu = a; rs2 = d; mr = r; mw = w; f3 = f; rd = dst; rw = we_rd;
    endtask

    task automatic test_reset();
        issue(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0);
        w_valid = 1'b0; w_alu = '0; w_rs2 = '0; w_mr = 1'b0; w_mw = 1'b0;
        w_f3 = 3'd0; w_rd = 5'd0; w_rw = 1'b0;
        b32.ack = 1'b0; b32.rdata = '0; b64.ack = 1'b0; b64.rdata = '0;
        rst_n = 1'b0;
        repeat (2) tick();
        n_chk++; if ({ov, orw, stall, omis, b32.req} !== 5'b0) begin n_fail++; $display("FAIL reset_ctl32: got %b want 00000", {ov, orw, stall, omis, b32.req}); end
        n_chk++; if ({ord, ores} !== 37'h0) begin n_fail++; $display("FAIL reset_data32: got %h want 0", {ord, ores}); end
        n_chk++; if ({w_ov, w_orw, w_stall, w_omis, b64.req, w_ord, w_ores} !== 74'h0) begin n_fail++; $display("FAIL reset64: got %h want 0", {w_ov, w_orw, w_stall, w_omis, b64.req, w_ord, w_ores}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_store_byte();
        int stalls = 0;
        issue(1'b1, 32'h1003, 32'h0000_00A5, 1'b0, 1'b1, 3'd0, 5'd0, 1'b0);
        tick();
        valid = 1'b0;
        n_chk++; if ({b32.req, b32.we} !== 2'b11) begin n_fail++; $display("FAIL sb_req: got %b want 11", {b32.req, b32.we}); end
        n_chk++; if (b32.addr !== 32'h1000) begin n_fail++; $display("FAIL sb_addr: got %h want 00001000", b32.addr); end
        n_chk++; if (b32.sel !== 4'b1000) begin n_fail++; $display("FAIL sb_sel: got %b want 1000", b32.sel); end
        n_chk++; if (b32.wdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h want a5a5a5a5", b32.wdata); end
        for (int i = 0; i < 3; i++) begin
            if (stall) stalls++;
            if (i == 2) b32.ack = 1'b1;
            tick();
        end
        b32.ack = 1'b0;
        n_chk++; if (stalls !== 3) begin n_fail++; $display("FAIL sb_stall_cycles: got %0d want 3", stalls); end
        n_chk++; if ({ov, orw, stall, b32.req} !== 4'b1000) begin n_fail++; $display("FAIL sb_done: got %b want 1000", {ov, orw, stall, b32.req}); end
        tick();
        n_chk++; if (ov !== 1'b0) begin n_fail++; $display("FAIL sb_pulse: got %b want 0", ov); end
    endtask

    task automatic test_load_half();
        for (int k = 0; k < 2; k++) begin
            issue(1'b1, 32'h2002, 32'h0, 1'b1, 1'b0, (k == 0) ? 3'd1 : 3'd5, 5'd5, 1'b1);
            tick();
            valid = 1'b0;
            n_chk++; if ({b32.req, b32.we, b32.sel} !== 6'b10_1100) begin n_fail++; $display("FAIL lh_sel%0d: got %b want 101100", k, {b32.req, b32.we, b32.sel}); end
            n_chk++; if (b32.addr !== 32'h2000) begin n_fail++; $display("FAIL lh_addr%0d: got %h want 00002000", k, b32.addr); end
            b32.ack = 1'b1; b32.rdata = 32'h8001_1234;
            tick();
            b32.ack = 1'b0;
            n_chk++; if ({ov, orw, ord} !== {2'b11, 5'd5}) begin n_fail++; $display("FAIL lh_ctl%0d: got %b want 1100101", k, {ov, orw, ord}); end
            n_chk++; if (ores !== ((k == 0) ? 32'hFFFF_8001 : 32'h0000_8001)) begin n_fail++; $display("FAIL lh_result%0d: got %h want %h", k, ores, (k == 0) ? 32'hFFFF_8001 : 32'h0000_8001); end
        end
    endtask

    task automatic test_word64();
        w_valid = 1'b1; w_alu = 64'h4; w_mr = 1'b1; w_mw = 1'b0; w_f3 = 3'd2; w_rd = 5'd9; w_rw = 1'b1;
        tick();
        w_valid = 1'b0;
        n_chk++; if (b64.sel !== 8'hF0) begin n_fail++; $display("FAIL lw64_sel: got %h want f0", b64.sel); end
        n_chk++; if (b64.addr !== 64'h0) begin n_fail++; $display("FAIL lw64_addr: got %h want 0", b64.addr); end
        b64.ack = 1'b1; b64.rdata = 64'h8000_0000_1111_1111;
        tick();
        b64.ack = 1'b0;
        n_chk++; if (w_ores !== 64'hFFFF_FFFF_8000_0000) begin n_fail++; $display("FAIL lw64_result: got %h want ffffffff80000000", w_ores); end
        n_chk++; if ({w_ov, w_orw, w_ord} !== {2'b11, 5'd9}) begin n_fail++; $display("FAIL lw64_ctl: got %b want 1101001", {w_ov, w_orw, w_ord}); end
        w_valid = 1'b1; w_alu = 64'h8; w_rs2 = 64'h1234_5678_DEAD_BEEF; w_mr = 1'b0; w_mw = 1'b1; w_rw = 1'b0;
        tick();
        w_valid = 1'b0;
        n_chk++; if ({b64.addr, b64.sel} !== {64'h8, 8'h0F}) begin n_fail++; $display("FAIL sw64_addr_sel: got %h/%h want 8/0f", b64.addr, b64.sel); end
        n_chk++; if (b64.wdata !== 64'hDEAD_BEEF_DEAD_BEEF) begin n_fail++; $display("FAIL sw64_wdata: got %h want deadbeefdeadbeef", b64.wdata); end
        b64.ack = 1'b1;
        tick();
        b64.ack = 1'b0;
        n_chk++; if ({w_ov, w_orw, w_stall} !== 3'b100) begin n_fail++; $display("FAIL sw64_done: got %b want 100", {w_ov, w_orw, w_stall}); end
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 32'h11, 32'h0, 1'b0, 1'b0, 3'd0, 5'd1, 1'b1);
        tick();
        n_chk++; if ({ov, orw, ord, ores} !== {2'b11, 5'd1, 32'h11}) begin n_fail++; $display("FAIL b2b_alu0: got %b/%h want 11_00001/11", {ov, orw, ord}, ores); end
        issue(1'b1, 32'h22, 32'h0, 1'b0, 1'b0, 3'd0, 5'd2, 1'b1);
        b32.rdata = 32'hCAFE_F00D;
        tick();
        n_chk++; if ({ov, ord, ores} !== {1'b1, 5'd2, 32'h22}) begin n_fail++; $display("FAIL b2b_alu1: got %b/%h want 1_00010/22", {ov, ord}, ores); end
        issue(1'b1, 32'h3000, 32'h0, 1'b1, 1'b0, 3'd2, 5'd3, 1'b1);
        tick();
        valid = 1'b0;
        n_chk++; if ({ov, stall, b32.req} !== 3'b011) begin n_fail++; $display("FAIL b2b_req: got %b want 011", {ov, stall, b32.req}); end
        b32.ack = 1'b1;
        tick();
        b32.ack = 1'b0;
        n_chk++; if ({ov, orw, ord, ores} !== {2'b11, 5'd3, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL b2b_load: got %b/%h want 11_00011/cafef00d", {ov, orw, ord}, ores); end
    endtask

    task automatic test_ack_idle();
        b32.ack = 1'b1;
        repeat (2) tick();
        b32.ack = 1'b0;
        n_chk++; if ({ov, stall, b32.req} !== 3'b000) begin n_fail++; $display("FAIL ack_idle: got %b want 000", {ov, stall, b32.req}); end
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 32'h500, 32'h0, 1'b1, 1'b0, 3'd2, 5'd7, 1'b1);
        tick();
        valid = 1'b0;
        n_chk++; if (b32.req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got %b want 1", b32.req); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if ({b32.req, ov, stall} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_abort: got %b want 000", {b32.req, ov, stall}); end
        tick();
        rst_n = 1'b1;
        issue(1'b1, 32'h77, 32'h0, 1'b0, 1'b0, 3'd0, 5'd4, 1'b1);
        tick();
        valid = 1'b0;
        n_chk++; if ({ov, orw, ord, ores} !== {2'b11, 5'd4, 32'h77}) begin n_fail++; $display("FAIL rst_mid_next: got %b/%h want 11_00100/77", {ov, orw, ord}, ores); end
        tick();
    endtask

    task automatic test_misalign();
        issue(1'b1, 32'h1001, 32'h0, 1'b1, 1'b0, 3'd2, 5'd6, 1'b1);
        tick();
        valid = 1'b0;
`ifdef RV_LSU_MISALIGN_TRAP_EN
        n_chk++; if ({b32.req, stall, ov, omis, orw} !== 5'b00110) begin n_fail++; $display("FAIL mis_trap_ctl: got %b want 00110", {b32.req, stall, ov, omis, orw}); end
        n_chk++; if (ores !== 32'h1001) begin n_fail++; $display("FAIL mis_trap_result: got %h want 00001001", ores); end
        tick();
        n_chk++; if ({ov, omis} !== 2'b00) begin n_fail++; $display("FAIL mis_trap_pulse: got %b want 00", {ov, omis}); end
`else
        n_chk++; if ({b32.req, b32.sel, omis} !== 6'b1_1111_0) begin n_fail++; $display("FAIL mis_force_sel: got %b want 111110", {b32.req, b32.sel, omis}); end
        n_chk++; if (b32.addr !== 32'h1000) begin n_fail++; $display("FAIL mis_force_addr: got %h want 00001000", b32.addr); end
        b32.ack = 1'b1; b32.rdata = 32'h1234_5678;
        tick();
        b32.ack = 1'b0;
        n_chk++; if ({ov, omis, ores} !== {2'b10, 32'h1234_5678}) begin n_fail++; $display("FAIL mis_force_result: got %b/%h want 10/12345678", {ov, omis}, ores); end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_store_byte();
        test_load_half();
        test_word64();
        test_back_to_back();
        test_ack_idle();
        test_reset_mid();
        test_misalign();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rv_lsu_stage.md
Name: rv_lsu_stage

Overview:
Parametrised load/store pipeline stage. It sits between execute and writeback and generalises the existing memory stage to XLEN 32/64. Unlike the earlier stage, it drives a req/ack data bus, holds the pipeline while an access is outstanding, and returns sign- or zero-extended load data to writeback. Non-memory instructions pass through with fixed 1-cycle latency.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
SEL_W, XLEN/8, byte-enable width; derived, not overridable

Ports:
i_clk  in  1  clock
i_reset_n  in  1  async active-low reset
i_valid  in  1  execute stage has an instruction
o_stall  out  1  stage busy; upstream must hold its outputs
i_alu_result  in  XLEN  effective address or ALU result
i_rs2_val  in  XLEN  store data
i_mem_read  in  1  load
i_mem_write  in  1  store
i_funct3  in  3  size/sign: [1:0] 0=B 1=H 2=W 3=D; [2]=unsigned
i_rd  in  5  destination register
i_reg_write  in  1  writes rd
o_bus_req  out  1  access request
o_bus_we  out  1  1=store
o_bus_addr  out  XLEN  address, low log2(SEL_W) bits zero
o_bus_sel  out  SEL_W  byte enables
o_bus_wdata  out  XLEN  lane-replicated store data
i_bus_ack  in  1  access complete; rdata valid on loads
i_bus_rdata  in  XLEN  load data
o_valid  out  1  result valid for writeback (1-cycle pulse)
o_rd  out  5  destination register
o_reg_write  out  1  write enable qualified by o_valid
o_result  out  XLEN  extended load data or passed ALU result
o_misalign  out  1  misaligned access flag (optional feature)

Behaviour:
- Reset: all outputs 0; FSM in IDLE. Reset asserted mid-access aborts it: o_bus_req drops immediately and the access is lost.
- Capture: inputs are registered when i_valid && !o_stall. o_stall = (state != IDLE).
- States:
  - IDLE: a non-memory op produces o_valid=1 next cycle with o_result=i_alu_result. A load or store goes to REQ.
  - REQ: o_bus_req=1. addr, we, sel and wdata are held stable until i_bus_ack=1 is sampled. On ack, go to IDLE, o_valid=1 next cycle. An ack in the first REQ cycle is legal (1 wait-free access = 2-cycle latency).
- i_bus_ack outside REQ is ignored.
- Byte enables: B -> one bit at addr[lsb]; H -> two bits at the aligned half; W -> 4 bits at the aligned word (XLEN=64 uses addr[2]); D -> all ones.
- D with XLEN=32 is treated as W.
- wdata: B replicates byte 0 across all lanes; H replicates the low half; W replicates the low word when XLEN=64; D passes through.
- Load extraction: select the lane by address, then sign-extend if funct3[2]=0, else zero-extend to XLEN.
- Stores: o_valid pulses but o_reg_write=0.
- o_reg_write = registered i_reg_write && o_valid.

Optional Feature:
Macro: RV_LSU_MISALIGN_TRAP_EN
- Defined: an access where addr is not a multiple of its size skips REQ. It produces o_valid=1, o_misalign=1, o_reg_write=0 and o_result=address on the next cycle, with no bus request.
- Undefined: o_misalign is tied to 0. Low address bits below the access size are ignored, so the access is forced aligned.

Test Plan:
- XLEN=32, SB addr 0x1003, rs2=0x000000A5, ack after 2 cycles -> sel=4'b1000, wdata=0xA5A5A5A5, o_stall high 3 cycles, o_valid pulse with o_reg_write=0.
- XLEN=32, LH addr 0x2002, rdata=0x8001_1234 -> sel=4'b1100, o_result=0xFFFF8001. Same access as LHU -> 0x00008001.
- XLEN=64, LW addr 0x4, rdata=0x8000_0000_1111_1111 -> sel=8'hF0, o_result=0xFFFFFFFF80000000.
- Back-to-back ALU op, ALU op, load with ack in the first REQ cycle -> o_valid on 3 consecutive results; load result 2 cycles after capture.
- Reset asserted while in REQ before ack -> o_bus_req=0 immediately, o_valid=0. After release, state is IDLE and the next op works.
- With RV_LSU_MISALIGN_TRAP_EN, LW addr 0x1001 -> no o_bus_req, o_misalign=1, o_result=0x1001. Without the macro -> access at 0x1000 with sel=4'b1111.
